// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for the 4-bit combinational ALU: buffers commands, issues them one at a time,
// and holds each result for a consumer. Optional accumulator chaining: `ALU_SEQ_ACC_CHAIN_EN.
module alu_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [3:0]                    cmd_a,
    input  logic [3:0]                    cmd_b,
    input  logic [2:0]                    cmd_op,
    input  logic                          cmd_chain,
    output logic [3:0]                    alu_a,
    output logic [3:0]                    alu_b,
    output logic [2:0]                    alu_control,
    input  logic [3:0]                    alu_result,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [3:0]                    rsp_result,
    output logic [2:0]                    rsp_op,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   cmd_count,
    output logic [1:0]                    dbg_state
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits for ready, and rsp_* stay frozen while rsp_valid is high and unaccepted.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    typedef struct packed {
        logic       chain;
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } entry_t;

    state_t         state_q, state_d;
    entry_t         mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q;
    entry_t         head;
    logic           push, pop, capture, release_rsp;
    logic           fifo_nonempty;
    logic [3:0]     a_sel;

    assign fifo_nonempty = (count_q != '0);
    assign cmd_ready     = (count_q != CW'(FIFO_DEPTH));
    assign push          = cmd_valid && cmd_ready;
    assign head          = mem[rd_ptr_q];
    assign busy          = (state_q != S_IDLE) || fifo_nonempty;
    assign cmd_count     = count_q;
    assign dbg_state     = state_q;

`ifdef ALU_SEQ_ACC_CHAIN_EN
    logic [3:0] acc_q;

    assign a_sel = head.chain ? acc_q : head.a;

    // The accumulator follows every captured result, chained or not.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= 4'd0;
        end else if (capture) begin
            acc_q <= alu_result;
        end
    end
`else
    logic unused_chain;

    assign a_sel        = head.a;
    assign unused_chain = head.chain;
`endif

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        capture     = 1'b0;
        release_rsp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                capture = 1'b1;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_valid && rsp_ready) begin
                    release_rsp = 1'b1;
                    if (fifo_nonempty) begin
                        pop     = 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Storage needs no reset: occupancy and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= '{chain: cmd_chain, op: cmd_op, a: cmd_a, b: cmd_b};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Operand registers hold the last issued command so the ALU inputs stay quiet while idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a       <= 4'd0;
            alu_b       <= 4'd0;
            alu_control <= 3'd0;
        end else if (pop) begin
            alu_a       <= a_sel;
            alu_b       <= head.b;
            alu_control <= head.op;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_result <= 4'd0;
            rsp_op     <= 3'd0;
        end else if (capture) begin
            rsp_valid  <= 1'b1;
            rsp_result <= alu_result;
            rsp_op     <= alu_control;
        end else if (release_rsp) begin
            rsp_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: directed steps plus random traffic against an in-order reference
// model; honours `ALU_SEQ_ACC_CHAIN_EN when the design is built with it.
module tb_alu_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_a, cmd_b;
    logic [2:0]    cmd_op;
    logic          cmd_chain;
    logic [3:0]    alu_a, alu_b;
    logic [2:0]    alu_control;
    logic [3:0]    alu_result;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [3:0]    rsp_result;
    logic [2:0]    rsp_op;
    logic          busy;
    logic [CW-1:0] cmd_count;
    logic [1:0]    dbg_state;

    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    logic [6:0]    exp_q[$];
    logic [6:0]    got_q[$];
    int            hs_cyc[$];
    logic [3:0]    acc_m = 4'd0;
    logic          hold_prev = 1'b0;
    logic [3:0]    hold_res;
    logic [2:0]    hold_op;
    logic          rand_ready = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [3:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op);
        case (op)
            3'd0:    return 4'(a + b);
            3'd1:    return 4'(a - b);
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return ~a;
            default: return 4'd0;
        endcase
    endfunction

    assign alu_result = alu_ref(alu_a, alu_b, alu_control);

    alu_cmd_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_chain(cmd_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_op(rsp_op),
        .busy(busy), .cmd_count(cmd_count), .dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected result of an accepted command, evaluated in acceptance order.
    task automatic model_push();
        logic [3:0] a_eff;
        logic [3:0] r;
        a_eff = cmd_a;
`ifdef ALU_SEQ_ACC_CHAIN_EN
        if (cmd_chain) a_eff = acc_m;
`endif
        r = alu_ref(a_eff, cmd_b, cmd_op);
        acc_m = r;
        exp_q.push_back({cmd_op, r});
    endtask

    // Called just after a falling edge: inputs are settled and outputs are what the next
    // rising edge will see, so handshakes are decided here.
    task automatic step();
        logic [6:0] e;
        if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
        if (hold_prev) begin
            check("rsp_hold_valid", rsp_valid, 1);
            check("rsp_hold_result", rsp_result, hold_res);
            check("rsp_hold_op", rsp_op, hold_op);
        end
        if (rst_n && cmd_valid && cmd_ready) model_push();
        if (rst_n && rsp_valid && rsp_ready) begin
            got_q.push_back({rsp_op, rsp_result});
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("rsp_without_cmd", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("rsp_scoreboard", {rsp_op, rsp_result}, e);
            end
        end
        hold_prev = rst_n && rsp_valid && !rsp_ready;
        hold_res  = rsp_result;
        hold_op   = rsp_op;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                        input logic chain);
        int   n;
        logic ok;
        n = 0;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_chain = chain; cmd_valid = 1'b1;
        do begin
            ok = cmd_ready;
            step();
            n++;
        end while (!ok && n < 200);
        cmd_valid = 1'b0;
        check("send_accept", ok, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            step();
            n++;
        end
        check("drain_done", (exp_q.size() == 0) && !busy, 1);
    endtask

    task automatic clear_logs();
        got_q.delete();
        hs_cyc.delete();
    endtask

    initial begin
        logic ok;
        int   n;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
        cmd_chain = 1'b0; rsp_ready = 1'b0;
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;

        // Reset values
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_op", rsp_op, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_control", alu_control, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_cmd_count", cmd_count, 0);

        // Latency of a single add
        rsp_ready = 1'b1;
        clear_logs();
        send(4'b0101, 4'b0011, 3'b000, 1'b0);
        check("lat_count_after_push", cmd_count, 1);
        check("lat_alu_not_yet", {alu_a, alu_b}, 8'h00);
        step();
        check("lat_alu_a", alu_a, 4'b0101);
        check("lat_alu_b", alu_b, 4'b0011);
        check("lat_alu_control", alu_control, 3'b000);
        check("lat_rsp_not_yet", rsp_valid, 0);
        step();
        check("lat_rsp_valid", rsp_valid, 1);
        check("lat_rsp_result", rsp_result, 4'b1000);
        check("lat_rsp_op", rsp_op, 3'b000);
        drain();

        // Back-to-back sub/and/or/not
        clear_logs();
        send(4'b1000, 4'b0010, 3'b001, 1'b0);
        send(4'b1100, 4'b1010, 3'b010, 1'b0);
        send(4'b1100, 4'b1010, 3'b011, 1'b0);
        send(4'b1010, 4'b0000, 3'b100, 1'b0);
        drain();
        check("b2b_count", got_q.size(), 4);
        if (got_q.size() == 4) begin
            check("b2b_r0", got_q[0][3:0], 4'b0110);
            check("b2b_r1", got_q[1][3:0], 4'b1000);
            check("b2b_r2", got_q[2][3:0], 4'b1110);
            check("b2b_r3", got_q[3][3:0], 4'b0101);
            for (int i = 1; i < 4; i++) check("b2b_spacing", hs_cyc[i] - hs_cyc[i-1], 2);
        end

        // FIFO full and backpressure
        rsp_ready = 1'b0;
        clear_logs();
        for (int i = 0; i < 5; i++)
            send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 4)), 1'b0);
        cmd_a = 4'($urandom_range(0, 15)); cmd_b = 4'($urandom_range(0, 15));
        cmd_op = 3'b000; cmd_chain = 1'b0; cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("full_cmd_ready", cmd_ready, 0);
            check("full_count", cmd_count, DEPTH);
            check("full_rsp_valid", rsp_valid, 1);
            check("full_rsp_held", rsp_result, exp_q[0][3:0]);
            step();
        end
        rsp_ready = 1'b1;
        n = 0;
        do begin
            ok = cmd_ready;
            step();
            n++;
        end while (!ok && n < 100);
        cmd_valid = 1'b0;
        check("full_sixth_accept", ok, 1);
        drain();
        check("full_all_done", got_q.size(), 6);

        // Reset while a result is held and two commands wait
        rsp_ready = 1'b0;
        clear_logs();
        send(4'b0001, 4'b0001, 3'b000, 1'b0);
        send(4'b0010, 4'b0001, 3'b000, 1'b0);
        send(4'b0011, 4'b0001, 3'b000, 1'b0);
        n = 0;
        while (!rsp_valid && n < 20) begin step(); n++; end
        check("mid_rsp_valid", rsp_valid, 1);
        check("mid_count", cmd_count, 2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_q.delete();
        acc_m = 4'd0;
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_count", cmd_count, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_alu", {alu_a, alu_b, 1'b0, alu_control}, 12'h000);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("mid_no_stale", rsp_valid, 0);
            step();
        end
        check("mid_no_stale_hs", got_q.size(), 0);

        // Reserved opcode and 4-bit wrap
        clear_logs();
        send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 3'b111, 1'b0);
        send(4'b0010, 4'b1000, 3'b001, 1'b0);
        send(4'b1111, 4'b0001, 3'b000, 1'b0);
        drain();
        check("edge_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("edge_reserved", got_q[0], {3'b111, 4'b0000});
            check("edge_sub_wrap", got_q[1][3:0], 4'b1010);
            check("edge_add_wrap", got_q[2][3:0], 4'b0000);
        end

        // Accumulator chaining
        clear_logs();
        send(4'b0101, 4'b0011, 3'b000, 1'b0);
        send(4'b0110, 4'b0001, 3'b000, 1'b1);
        drain();
        check("chain_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("chain_first", got_q[0][3:0], 4'b1000);
`ifdef ALU_SEQ_ACC_CHAIN_EN
            check("chain_second", got_q[1][3:0], 4'b1001);
`else
            check("chain_second", got_q[1][3:0], 4'b0111);
`endif
        end

        // Random traffic with random consumer backpressure
        rand_ready = 1'b1;
        clear_logs();
        for (int i = 0; i < 60; i++) begin
            send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            check("rand_ready_rule", cmd_ready, cmd_count != CW'(DEPTH));
            n = $urandom_range(0, 2);
            for (int j = 0; j < n; j++) step();
        end
        rand_ready = 1'b0;
        rsp_ready = 1'b1;
        drain();
        check("rand_all_done", got_q.size(), 60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-side initiator for the 4-bit ALU. It accepts operation commands over a valid/ready handshake, buffers them in a small FIFO, and drives the ALU operand and control inputs one command at a time. It captures each ALU result into a register and presents it to a consumer over a second valid/ready handshake. It sits between a command source (testbench or controller) and the combinational ALU, and it owns all sequencing around that ALU.

## Interface
- Parameters:
  - `FIFO_DEPTH`, default 4: command FIFO entries; power of two, 2..16.
- Clock and reset:
  - `clk`, in, 1: single clock; all state changes on the rising edge.
  - `rst_n`, in, 1: reset, synchronous, active-low.
- Command port:
  - `cmd_valid`, in, 1: a command is offered.
  - `cmd_ready`, out, 1: the FIFO can accept a command.
  - `cmd_a`, in, 4: operand A.
  - `cmd_b`, in, 4: operand B.
  - `cmd_op`, in, 3: opcode.
    - 000 add, 001 sub, 010 and, 011 or, 100 not A.
    - 101..111 reserved.
  - `cmd_chain`, in, 1: use the accumulator as A (see Configuration).
- ALU port:
  - `alu_a`, out, 4: ALU operand A.
  - `alu_b`, out, 4: ALU operand B.
  - `alu_control`, out, 3: ALU opcode.
  - `alu_result`, in, 4: ALU combinational result.
- Response port:
  - `rsp_valid`, out, 1: a result is held.
  - `rsp_ready`, in, 1: the consumer accepts the result.
  - `rsp_result`, out, 4: captured result.
  - `rsp_op`, out, 3: opcode that produced `rsp_result`.
- Status:
  - `busy`, out, 1: high when the FSM is not in IDLE or the FIFO is non-empty.
  - `cmd_count`, out, $clog2(FIFO_DEPTH)+1: FIFO occupancy.

## Operation
- FIFO:
  - A push occurs when `cmd_valid` and `cmd_ready` are both high; the entry is {chain, op, a, b}.
  - `cmd_ready` = (count != FIFO_DEPTH). It does not depend on a same-cycle pop.
  - A simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: if the FIFO is non-empty, pop the head into the operand registers and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: the operand registers drive `alu_*`. At the end of the cycle, latch `alu_result` into `rsp_result` and the opcode into `rsp_op`, set `rsp_valid`, and go to RESP.
  - RESP: hold `rsp_*` and `alu_*` stable.
    - On a handshake (`rsp_valid` and `rsp_ready`) with the FIFO non-empty: pop, clear `rsp_valid`, go to ISSUE.
    - On a handshake with the FIFO empty: clear `rsp_valid`, go to IDLE.
- `alu_*` retain their last-issued values in IDLE.
- Arithmetic is done in the ALU with 4-bit modulo results: 0101+0011=1000; 0010-1000=1010.
- The block does not filter reserved opcodes; it forwards them. The ALU returns 0000 for them.
- Reset (`rst_n` low at a rising edge) applies in any state, including mid-operation:
  - FIFO flushed, count 0, state IDLE, any in-flight command discarded.
  - Reset values:
    - `rsp_valid`, `rsp_result`, `rsp_op`: 0.
    - `alu_a`, `alu_b`, `alu_control`: 0.
    - `busy`: 0.
    - `cmd_ready`: 1.
    - Accumulator: 0.

## Timing
- Latency: a command pushed at edge k into an empty FIFO with the FSM in IDLE is popped at edge k+1. `alu_*` change after edge k+1, and `rsp_valid` rises after edge k+2.
- Throughput: at most one result every 2 cycles, when `rsp_ready` is held high and the FIFO stays non-empty.
- `rsp_valid`, once asserted, stays high with `rsp_result` and `rsp_op` stable until the handshake.
- A command pushed into an empty FIFO at the same edge the FSM evaluates IDLE is not popped until the following edge.
- All outputs are registered, except `cmd_ready`, `busy` and `cmd_count`. These three are decoded from registered state only, with no combinational path from inputs.

## Configuration
- Macro: `ALU_SEQ_ACC_CHAIN_EN`.
- When defined:
  - A 4-bit accumulator loads `alu_result` at every ISSUE capture.
  - For a popped entry with chain=1, the accumulator replaces `cmd_a` as the A operand.
- When undefined:
  - No accumulator is built.
  - `cmd_chain` remains a port but is ignored; A always equals `cmd_a`.

## Test plan
- Reset, then push {a=0101, b=0011, op=000} with `rsp_ready`=1:
  - `alu_control`=000 one edge after the push.
  - `rsp_valid` rises 2 edges after the push, with `rsp_result`=1000 and `rsp_op`=000.
- Push sub 1000-0010, then and 1100&1010, then or 1100|1010, then not 1010, back-to-back, with `rsp_ready`=1:
  - Results in order: 0110, 1000, 1110, 0101.
  - Consecutive `rsp_valid` pulses are spaced 2 cycles apart.
- FIFO full and backpressure:
  - Hold `rsp_ready`=0 and push 6 commands.
  - `cmd_ready` drops when count=FIFO_DEPTH; the first result is held stable for 20 cycles.
  - After `rsp_ready` is released, all accepted commands complete in order and none is lost or duplicated.
- Reset mid-operation:
  - Assert `rst_n`=0 for one edge while in RESP with 2 entries queued.
  - Afterwards `rsp_valid`=0, count=0, `busy`=0, and `alu_*`=0; no stale result ever appears.
- Reserved opcode and wrap:
  - op=111 gives `rsp_result`=0000 and `rsp_op`=111.
  - 0010-1000 gives 1010.
  - 1111+0001 gives 0000.
- With `ALU_SEQ_ACC_CHAIN_EN` defined:
  - Send add 0101+0011 (result 1000), then add with chain=1 and b=0001: result 1001.
  - Without the macro, the same sequence gives cmd_a+0001.
